// File: rtl/pg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pg_loader
// Purpose  : Byte-stream to program-memory downloader (sync, length, LE words,
//            byte-gap timeout). Define PG_LOADER_CHKSUM_EN for trailing XOR check.
// Revision : 1.0 - initial release
// ============================================================================
module pg_loader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  PG_RST,
    output logic [DATA_W/8-1:0]   PG_WEN,
    output logic [DATA_W-1:0]     PG_DIN,
    output logic [ADDR_W-1:0]     PG_ADR,
    output logic                  PG_DONE,
    output logic                  load_err,
    output logic                  busy
);

    localparam int         c_BYTES  = DATA_W / 8;
    localparam int         c_BIDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int         c_TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [7:0] c_SYNC   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN_L = 3'd1,
        S_LEN_H = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
`ifdef PG_LOADER_CHKSUM_EN
        ,
        S_CHK   = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [c_BIDX_W-1:0]   bidx_q, bidx_d;
    logic [DATA_W-1:0]     word_q, word_d;
    logic [DATA_W-1:0]     pg_din_q, pg_din_d;
    logic                  pg_wen_q, pg_wen_d;
    logic [ADDR_W-1:0]     pg_adr_q, pg_adr_d;
    logic                  pg_rst_q, pg_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [c_TMO_W-1:0]    tmo_q, tmo_d;
`ifdef PG_LOADER_CHKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    logic [DATA_W-1:0]     w_word_next;
    logic [15:0]           w_len;
    logic                  w_fin;
    logic                  w_end_ok;
    logic                  w_end_bad;

    assign w_len = {rx_data, cnt_q[7:0]};

    // Bytes shift in from the top so the first (least significant) byte
    // ends up in the low lane once the word is complete.
    generate
        if (c_BYTES == 1) begin : g_narrow
            assign w_word_next = rx_data;
        end else begin : g_wide
            assign w_word_next = {rx_data, word_q[DATA_W-1:8]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        word_d    = word_q;
        pg_din_d  = pg_din_q;
        pg_wen_d  = 1'b0;
        pg_adr_d  = pg_adr_q;
        pg_rst_d  = pg_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        busy_d    = busy_q;
        tmo_d     = '0;
        w_fin     = 1'b0;
        w_end_ok  = 1'b0;
        w_end_bad = 1'b0;
`ifdef PG_LOADER_CHKSUM_EN
        chk_d     = chk_q;
`endif

        // Address advances in the cycle after the write strobe.
        if (pg_wen_q) begin
            pg_adr_d = pg_adr_q + ADDR_W'(1);
        end

        // busy is high exactly in the in-frame states the timeout guards.
        if (busy_q && !rx_valid) begin
            tmo_d = tmo_q + c_TMO_W'(1);
            if (tmo_q == c_TMO_W'(TIMEOUT - 1)) begin
                w_end_bad = 1'b1;
            end
        end

        if (rx_valid) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data == c_SYNC) begin
                        state_d  = S_LEN_L;
                        pg_rst_d = 1'b1;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        pg_adr_d = '0;
                        busy_d   = 1'b1;
                        bidx_d   = '0;
`ifdef PG_LOADER_CHKSUM_EN
                        chk_d    = 8'h00;
`endif
                    end
                end
                S_LEN_L: begin
                    cnt_d   = {8'h00, rx_data};
                    state_d = S_LEN_H;
                end
                S_LEN_H: begin
                    cnt_d  = w_len;
                    bidx_d = '0;
                    if (w_len == 16'd0) begin
                        w_fin = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d = w_word_next;
`ifdef PG_LOADER_CHKSUM_EN
                    chk_d  = chk_q ^ rx_data;
`endif
                    if (bidx_q == c_BIDX_W'(c_BYTES - 1)) begin
                        pg_din_d = w_word_next;
                        pg_wen_d = 1'b1;
                        bidx_d   = '0;
                        cnt_d    = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            w_fin = 1'b1;
                        end
                    end else begin
                        bidx_d = bidx_q + c_BIDX_W'(1);
                    end
                end
`ifdef PG_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (rx_data == chk_q) begin
                        w_end_ok = 1'b1;
                    end else begin
                        w_end_bad = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (w_fin) begin
`ifdef PG_LOADER_CHKSUM_EN
            state_d = S_CHK;
`else
            w_end_ok = 1'b1;
`endif
        end

        if (w_end_ok) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            pg_rst_d = 1'b0;
            busy_d   = 1'b0;
        end

        if (w_end_bad) begin
            state_d  = S_ERR;
            err_d    = 1'b1;
            pg_rst_d = 1'b1;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            pg_din_q <= '0;
            pg_wen_q <= 1'b0;
            pg_adr_q <= '0;
            pg_rst_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= '0;
`ifdef PG_LOADER_CHKSUM_EN
            chk_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            pg_din_q <= pg_din_d;
            pg_wen_q <= pg_wen_d;
            pg_adr_q <= pg_adr_d;
            pg_rst_q <= pg_rst_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
`ifdef PG_LOADER_CHKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign PG_RST   = pg_rst_q;
    assign PG_WEN   = {c_BYTES{pg_wen_q}};
    assign PG_DIN   = pg_din_q;
    assign PG_ADR   = pg_adr_q;
    assign PG_DONE  = done_q;
    assign load_err = err_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pg_loader
// Purpose  : Scoreboard bench for pg_loader: 16-bit and 32-bit/2-bit-address
//            instances driven by directed and random frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pg_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  rxd_a, rxd_b;
    logic        rxv_a, rxv_b;

    logic        pg_rst_a, done_a, err_a, busy_a;
    logic [1:0]  wen_a;
    logic [15:0] din_a, adr_a;

    logic        pg_rst_b, done_b, err_b, busy_b;
    logic [3:0]  wen_b;
    logic [31:0] din_b;
    logic [1:0]  adr_b;

    pg_loader #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(50)) u_dut_a (
        .clk(clk), .rst(rst), .rx_data(rxd_a), .rx_valid(rxv_a),
        .PG_RST(pg_rst_a), .PG_WEN(wen_a), .PG_DIN(din_a), .PG_ADR(adr_a),
        .PG_DONE(done_a), .load_err(err_a), .busy(busy_a)
    );

    pg_loader #(.DATA_W(32), .ADDR_W(2), .TIMEOUT(50)) u_dut_b (
        .clk(clk), .rst(rst), .rx_data(rxd_b), .rx_valid(rxv_b),
        .PG_RST(pg_rst_b), .PG_WEN(wen_b), .PG_DIN(din_b), .PG_ADR(adr_b),
        .PG_DONE(done_b), .load_err(err_b), .busy(busy_b)
    );

    typedef struct {
        logic [15:0] adr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    wr_t         e_a, e_b;
    logic [31:0] words_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wen_a !== 2'b00) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL write_a: unexpected write wen=%b adr=%h data=%h", wen_a, adr_a, din_a);
            end else begin
                e_a = exp_a.pop_front();
                if (wen_a !== 2'b11 || adr_a !== e_a.adr || din_a !== e_a.data[15:0]) begin
                    errors++;
                    $display("FAIL write_a: got wen=%b adr=%h data=%h expected wen=11 adr=%h data=%h",
                             wen_a, adr_a, din_a, e_a.adr, e_a.data[15:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (wen_b !== 4'h0) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL write_b: unexpected write wen=%h adr=%h data=%h", wen_b, adr_b, din_b);
            end else begin
                e_b = exp_b.pop_front();
                if (wen_b !== 4'hF || adr_b !== e_b.adr[1:0] || din_b !== e_b.data) begin
                    errors++;
                    $display("FAIL write_b: got wen=%h adr=%h data=%h expected wen=f adr=%h data=%h",
                             wen_b, adr_b, din_b, e_b.adr[1:0], e_b.data);
                end
            end
        end
    end

    task automatic send_byte(input int tgt, input logic [7:0] b, input int gap);
        if (tgt == 0) begin
            rxd_a = b;
            rxv_a = 1'b1;
        end else begin
            rxd_b = b;
            rxv_b = 1'b1;
        end
        @(negedge clk);
        rxv_a = 1'b0;
        rxv_b = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Compares {PG_DONE, load_err, PG_RST, busy}.
    task automatic check_status(input int tgt, input string name, input logic [3:0] exp);
        if (tgt == 0) check(name, {28'h0, done_a, err_a, pg_rst_a, busy_a}, {28'h0, exp});
        else          check(name, {28'h0, done_b, err_b, pg_rst_b, busy_b}, {28'h0, exp});
    endtask

    // Reference model: builds the frame from words_q and predicts every write
    // and the final status from the framing rules alone.
    task automatic run_frame(input int tgt, input bit bad);
        logic [7:0]  fr[$];
        logic [7:0]  chk;
        logic [31:0] w;
        logic [15:0] n;
        int          nbytes;
        bit          ok;
        wr_t         e;
        n      = 16'(words_q.size());
        nbytes = (tgt == 0) ? 2 : 4;
        chk    = 8'h00;
        fr.push_back(8'hA5);
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            w = words_q[i];
            if (tgt == 0) w = w & 32'h0000_FFFF;
            for (int k = 0; k < nbytes; k++) begin
                fr.push_back(w[8*k +: 8]);
                chk = chk ^ w[8*k +: 8];
            end
            e.data = w;
            e.adr  = (tgt == 0) ? 16'(i % 65536) : 16'(i % 4);
            if (tgt == 0) exp_a.push_back(e);
            else          exp_b.push_back(e);
        end
        ok = 1'b1;
`ifdef PG_LOADER_CHKSUM_EN
        fr.push_back(bad ? (chk ^ 8'h5A) : chk);
        ok = !bad;
`endif
        for (int j = 0; j < fr.size(); j++) begin
            send_byte(tgt, fr[j], (j == fr.size() - 1) ? 0 : int'($urandom_range(0, 3)));
        end
        check_status(tgt, ok ? "frame_done" : "frame_err", ok ? 4'b1000 : 4'b0110);
        @(negedge clk);
        check("writes_drained", (tgt == 0) ? exp_a.size() : exp_b.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        rxd_a = 8'h00;
        rxd_b = 8'h00;
        rxv_a = 1'b0;
        rxv_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state held with no input
        for (int c = 0; c < 10; c++) begin
            repeat (100) @(negedge clk);
            check("reset_a", {10'h0, pg_rst_a, done_a, err_a, busy_a, wen_a, adr_a},
                  {10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000});
        end
        check("reset_b", {24'h0, pg_rst_b, done_b, err_b, busy_b, wen_b},
              {24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
        check("reset_din", {din_a, din_b[15:0]}, 32'h0);

        // Directed 16-bit frame
        words_q = '{32'h1234, 32'h5678};
        run_frame(0, 1'b0);

        // Junk while idle/done is ignored, then an empty frame
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'hFF, 0);
        send_byte(0, 8'h11, 2);
        check_status(0, "junk_ignored", 4'b1000);
        words_q = {};
        run_frame(0, 1'b0);

        // Byte-gap timeout mid-word
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h34, 0);
        check_status(0, "busy_in_frame", 4'b0011);
        repeat (60) @(negedge clk);
        check_status(0, "timeout_err", 4'b0110);
        send_byte(0, 8'hA5, 0);
        check_status(0, "sync_clears_err", 4'b0011);
        check("sync_adr", {16'h0, adr_a}, 32'h0);
        repeat (60) @(negedge clk);
        check_status(0, "timeout_err2", 4'b0110);

        // Address wrap on the 2-bit address instance
        words_q = '{32'h0403_0201, 32'h8877_6655, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE};
        run_frame(1, 1'b0);

`ifdef PG_LOADER_CHKSUM_EN
        words_q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        run_frame(1, 1'b1);
        words_q = '{32'h0000_ABCD};
        run_frame(0, 1'b1);
`endif

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            int tgt;
            int n;
            tgt = int'($urandom_range(0, 1));
            n   = int'($urandom_range(0, 7));
            words_q = {};
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            run_frame(tgt, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("final_queue_a", exp_a.size(), 0);
        check("final_queue_b", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
